matrix_row_sequencer: RTL and testbench

- Initiator on the inside (compute-side) port of the ping-pong matrix memory.
- After the outside SRAM load completes, fetches operand rows one at a time and presents each to the MAC array over a valid/ready stream.
- Accepts one result row per operand row and writes it back to the result region.
- One transaction outstanding at a time; reads and writes share a single address bus.

---
 rtl/matrix_row_sequencer.sv | 136 +++++++++++++
 tb/tb_matrix_row_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_row_sequencer.sv
// Compute-side initiator for the ping-pong matrix memory: fetches operand rows,
// streams them to the MAC array and writes each returned result row back.
module matrix_row_sequencer #(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 128,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  row_count,
    input  logic [AWIDTH-1:0] src_base,
    input  logic [AWIDTH-1:0] dst_base,
    output logic              busy,
    output logic              done,
    output logic              error,
    input  logic              sram_load_isfinsh,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_read_valid,
    input  logic              mem_read_finish,
    input  logic [DWIDTH-1:0] mem_dout,
    output logic              mem_wreq,
    output logic [DWIDTH-1:0] mem_din,
    output logic              row_valid,
    output logic [DWIDTH-1:0] row_data,
    input  logic              row_ready,
    input  logic              res_valid,
    input  logic [DWIDTH-1:0] res_data,
    output logic              res_ready
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE, WAIT_LOAD, RD_REQ, PRESENT, WAIT_RES, WRITE, FINISH
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [CNT_W-1:0]  r_rowCount;
    logic [CNT_W-1:0]  r_rowIdx;
    logic [CNT_W-1:0]  w_idxNext;
    logic [AWIDTH-1:0] r_srcBase;
    logic [AWIDTH-1:0] r_dstBase;
    logic [TW-1:0]     r_tmoCnt;
    logic              w_accept;
    logic              w_timeout;
    logic              w_lastRow;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_lastRow = (r_rowIdx == (r_rowCount - CNT_W'(1)));
    // The index bumps on the edge leaving WRITE, so the next read address must see it early.
    assign w_idxNext = (r_state == WRITE) ? (r_rowIdx + CNT_W'(1)) : r_rowIdx;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE:      if (start) w_nextState = WAIT_LOAD;
            WAIT_LOAD: if (sram_load_isfinsh)
                           w_nextState = (r_rowCount == '0) ? FINISH : RD_REQ;
            RD_REQ: begin
                if (mem_read_finish) begin
                    w_nextState = PRESENT;
                end else if (r_tmoCnt == TW'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_nextState = FINISH;
                end
            end
            PRESENT:   if (row_valid && row_ready) w_nextState = WAIT_RES;
            WAIT_RES:  if (res_valid && res_ready) w_nextState = WRITE;
            WRITE:     w_nextState = w_lastRow ? FINISH : RD_REQ;
            FINISH:    w_nextState = IDLE;
            default:   w_nextState = IDLE;
        endcase
    end

    // Every output is registered from the upcoming state so it lines up with that state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            mem_read_valid <= 1'b0;
            mem_wreq       <= 1'b0;
            row_valid      <= 1'b0;
            res_ready      <= 1'b0;
            mem_addr       <= '0;
            mem_din        <= '0;
            row_data       <= '0;
            r_rowCount     <= '0;
            r_rowIdx       <= '0;
            r_srcBase      <= '0;
            r_dstBase      <= '0;
            r_tmoCnt       <= '0;
        end else begin
            busy           <= (w_nextState != IDLE) && (w_nextState != FINISH);
            done           <= (w_nextState == FINISH);
            mem_read_valid <= (w_nextState == RD_REQ);
            mem_wreq       <= (w_nextState == WRITE);
            row_valid      <= (w_nextState == PRESENT);
            res_ready      <= (w_nextState == WAIT_RES);
            r_tmoCnt       <= (r_state == RD_REQ) ? (r_tmoCnt + TW'(1)) : '0;

            if (w_accept) begin
                r_rowCount <= row_count;
                r_srcBase  <= src_base;
                r_dstBase  <= dst_base;
                r_rowIdx   <= '0;
                error      <= 1'b0;
            end else if (w_timeout) begin
                error      <= 1'b1;
            end

            if (r_state == WRITE)
                r_rowIdx <= r_rowIdx + CNT_W'(1);

            if (w_nextState == RD_REQ && r_state != RD_REQ)
                mem_addr <= r_srcBase + AWIDTH'(w_idxNext);
            else if (w_nextState == WRITE && r_state != WRITE)
                mem_addr <= r_dstBase + AWIDTH'(r_rowIdx);

            if (r_state == RD_REQ && mem_read_finish)
                row_data <= mem_dout;
            if (r_state == WAIT_RES && res_valid && res_ready)
                mem_din <= res_data;
        end
    end

endmodule

// File: tb/tb_matrix_row_sequencer.sv
// Directed bench for matrix_row_sequencer: acts as the memory and the MAC array
// cycle by cycle and checks addresses, data, timing and the error/abort paths.
module tb_matrix_row_sequencer;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [7:0]   row_count;
    logic [7:0]   src_base;
    logic [7:0]   dst_base;
    logic         busy;
    logic         done;
    logic         error;
    logic         sram_load_isfinsh;
    logic [7:0]   mem_addr;
    logic         mem_read_valid;
    logic         mem_read_finish;
    logic [127:0] mem_dout;
    logic         mem_wreq;
    logic [127:0] mem_din;
    logic         row_valid;
    logic [127:0] row_data;
    logic         row_ready;
    logic         res_valid;
    logic [127:0] res_data;
    logic         res_ready;

    int passCount;
    int checkCount;

    logic [7:0]   rdAddrs[$];
    logic [7:0]   wrAddrs[$];
    logic [127:0] wrData[$];
    int   doneCycle;
    int   firstRdCycle;
    int   rvCycles;
    int   wreqCycles;
    int   bothHigh;
    int   rowUnstable;
    int   busyLow;
    logic errAtDone;
    logic errAtCyc1;
    logic busyAtDone;

    matrix_row_sequencer #(.AWIDTH(8), .DWIDTH(128), .CNT_W(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .row_count(row_count),
        .src_base(src_base), .dst_base(dst_base), .busy(busy), .done(done),
        .error(error), .sram_load_isfinsh(sram_load_isfinsh), .mem_addr(mem_addr),
        .mem_read_valid(mem_read_valid), .mem_read_finish(mem_read_finish),
        .mem_dout(mem_dout), .mem_wreq(mem_wreq), .mem_din(mem_din),
        .row_valid(row_valid), .row_data(row_data), .row_ready(row_ready),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of operand memory at a given row address.
    function automatic logic [127:0] memWord(input logic [7:0] a);
        return {8{8'hA5, a}};
    endfunction

    // Start a job, then play memory and MAC array at each negedge until done or budget.
    task automatic runJob(input logic [7:0] cnt, input logic [7:0] src, input logic [7:0] dst,
                          input int finishLat, input int readyDelay, input int resDelay,
                          input int loadAt, input int secondStartAt, input int maxCycles);
        int rdAge;
        int rowAge;
        int resAge;
        logic resPending;
        logic [127:0] pendData;
        logic [127:0] prevRow;
        rdAddrs.delete(); wrAddrs.delete(); wrData.delete();
        doneCycle = -1; firstRdCycle = -1; rvCycles = 0; wreqCycles = 0;
        bothHigh = 0; rowUnstable = 0; busyLow = 0;
        errAtDone = 1'bx; errAtCyc1 = 1'bx; busyAtDone = 1'bx;
        rdAge = 0; rowAge = 0; resAge = 0; resPending = 1'b0;
        pendData = '0; prevRow = '0;
        @(negedge clk);
        row_count = cnt; src_base = src; dst_base = dst; start = 1'b1;
        sram_load_isfinsh = (loadAt <= 0);
        for (int cyc = 1; cyc <= maxCycles; cyc++) begin
            @(negedge clk);
            start = (cyc == secondStartAt);
            if (start) begin
                row_count = 8'd9; src_base = 8'h40; dst_base = 8'h50;
            end
            sram_load_isfinsh = (cyc >= loadAt);
            if (cyc == 1) errAtCyc1 = error;
            if (mem_read_valid && mem_wreq) bothHigh++;
            mem_read_finish = 1'b0;
            if (mem_read_valid) begin
                rvCycles++;
                if (firstRdCycle < 0) firstRdCycle = cyc;
                if (rdAge == finishLat) begin
                    mem_read_finish = 1'b1;
                    mem_dout = memWord(mem_addr);
                    rdAddrs.push_back(mem_addr);
                end
                rdAge++;
            end else begin
                rdAge = 0;
            end
            if (mem_wreq) begin
                wreqCycles++;
                wrAddrs.push_back(mem_addr);
                wrData.push_back(mem_din);
            end
            res_valid = 1'b0;
            if (resPending) begin
                if (resAge >= resDelay) begin
                    res_valid = 1'b1;
                    res_data  = pendData;
                    if (res_ready) resPending = 1'b0;
                end
                resAge++;
            end
            row_ready = 1'b0;
            if (row_valid) begin
                if (rowAge > 0 && row_data !== prevRow) rowUnstable++;
                prevRow = row_data;
                if (rowAge >= readyDelay) begin
                    row_ready  = 1'b1;
                    pendData   = ~row_data;
                    resPending = 1'b1;
                    resAge     = 0;
                end
                rowAge++;
            end else begin
                rowAge = 0;
            end
            if (!busy && !done) busyLow++;
            if (done) begin
                doneCycle = cyc; errAtDone = error; busyAtDone = busy;
                break;
            end
        end
        start = 1'b0; row_ready = 1'b0; res_valid = 1'b0; mem_read_finish = 1'b0;
    endtask

    // Count cycles with any job activity while nothing has been started.
    task automatic idleWatch(input int n, output int activity);
        activity = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy || done || mem_read_valid || mem_wreq) activity++;
        end
    endtask

    task automatic checkRowsMoved(input string tag, input logic [7:0] src, input logic [7:0] dst,
                                  input int n);
        logic [7:0] a;
        checkCount++;
        if (rdAddrs.size() !== n || wrAddrs.size() !== n)
            $display("[TB] FAIL %s_count reads %0d writes %0d want %0d", tag, rdAddrs.size(), wrAddrs.size(), n);
        else passCount++;
        for (int i = 0; i < n && i < rdAddrs.size() && i < wrAddrs.size(); i++) begin
            a = src + 8'(i);
            checkCount++;
            if (rdAddrs[i] !== a) $display("[TB] FAIL %s_rd_addr%0d got %h want %h", tag, i, rdAddrs[i], a);
            else passCount++;
            checkCount++;
            if (wrData[i] !== ~memWord(a)) $display("[TB] FAIL %s_wr_data%0d got %h want %h", tag, i, wrData[i], ~memWord(a));
            else passCount++;
            a = dst + 8'(i);
            checkCount++;
            if (wrAddrs[i] !== a) $display("[TB] FAIL %s_wr_addr%0d got %h want %h", tag, i, wrAddrs[i], a);
            else passCount++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkCount++;
        if ({busy, done, error, mem_read_valid, mem_wreq, row_valid, res_ready} !== 7'b0)
            $display("[TB] FAIL reset_ctrl got %b want 0000000", {busy, done, error, mem_read_valid, mem_wreq, row_valid, res_ready});
        else passCount++;
        checkCount++;
        if (mem_addr !== 8'h00 || mem_din !== '0 || row_data !== '0)
            $display("[TB] FAIL reset_data got addr %h din %h row %h want zeros", mem_addr, mem_din, row_data);
        else passCount++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int act;
        runJob(8'd3, 8'h10, 8'h80, 1, 0, 0, 1, -1, 200);
        checkCount++;
        if (doneCycle !== 17) $display("[TB] FAIL basic_done_cycle got %0d want 17", doneCycle);
        else passCount++;
        checkRowsMoved("basic", 8'h10, 8'h80, 3);
        checkCount++;
        if (errAtDone !== 1'b0 || busyAtDone !== 1'b0)
            $display("[TB] FAIL basic_err_busy_at_done got %b%b want 00", errAtDone, busyAtDone);
        else passCount++;
        checkCount++;
        if (bothHigh !== 0 || busyLow !== 0)
            $display("[TB] FAIL basic_overlap_busy got overlap %0d busylow %0d want 0 0", bothHigh, busyLow);
        else passCount++;
        idleWatch(5, act);
        checkCount++;
        if (act !== 0) $display("[TB] FAIL basic_tail_activity got %0d want 0", act);
        else passCount++;
    endtask

    task automatic test_wrap();
        runJob(8'd3, 8'hFE, 8'hFF, 0, 0, 0, 1, -1, 200);
        checkCount++;
        if (doneCycle !== 14) $display("[TB] FAIL wrap_done_cycle got %0d want 14", doneCycle);
        else passCount++;
        checkRowsMoved("wrap", 8'hFE, 8'hFF, 3);
    endtask

    task automatic test_zero_count();
        runJob(8'd0, 8'h33, 8'h44, 0, 0, 0, 1, -1, 50);
        checkCount++;
        if (doneCycle !== 2) $display("[TB] FAIL zero_done_cycle got %0d want 2", doneCycle);
        else passCount++;
        checkCount++;
        if (rvCycles !== 0 || wreqCycles !== 0)
            $display("[TB] FAIL zero_mem_access got rd %0d wr %0d want 0 0", rvCycles, wreqCycles);
        else passCount++;
    endtask

    task automatic test_load_hold();
        runJob(8'd1, 8'h05, 8'h06, 0, 0, 0, 11, -1, 100);
        checkCount++;
        if (firstRdCycle !== 12) $display("[TB] FAIL load_first_read got %0d want 12", firstRdCycle);
        else passCount++;
        checkCount++;
        if (busyLow !== 0) $display("[TB] FAIL load_busy_low got %0d want 0", busyLow);
        else passCount++;
        checkCount++;
        if (doneCycle !== 16) $display("[TB] FAIL load_done_cycle got %0d want 16", doneCycle);
        else passCount++;
    endtask

    task automatic test_timeout();
        int act;
        runJob(8'd2, 8'h90, 8'hA0, -1, 0, 0, 1, -1, 200);
        checkCount++;
        if (doneCycle !== 66) $display("[TB] FAIL tmo_done_cycle got %0d want 66", doneCycle);
        else passCount++;
        checkCount++;
        if (errAtDone !== 1'b1 || wreqCycles !== 0)
            $display("[TB] FAIL tmo_error got err %b writes %0d want 1 0", errAtDone, wreqCycles);
        else passCount++;
        idleWatch(3, act);
        checkCount++;
        if (error !== 1'b1) $display("[TB] FAIL tmo_error_sticky got %b want 1", error);
        else passCount++;
        runJob(8'd1, 8'h90, 8'hA0, 0, 0, 0, 1, -1, 50);
        checkCount++;
        if (errAtCyc1 !== 1'b0 || errAtDone !== 1'b0 || doneCycle !== 6)
            $display("[TB] FAIL tmo_error_clear got cyc1 %b done_err %b done_cyc %0d want 0 0 6", errAtCyc1, errAtDone, doneCycle);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        int act;
        runJob(8'd2, 8'h20, 8'h30, 0, 5, 7, 1, 4, 200);
        checkCount++;
        if (doneCycle !== 34) $display("[TB] FAIL stall_done_cycle got %0d want 34", doneCycle);
        else passCount++;
        checkCount++;
        if (rowUnstable !== 0) $display("[TB] FAIL stall_row_stable got %0d changes want 0", rowUnstable);
        else passCount++;
        checkRowsMoved("stall", 8'h20, 8'h30, 2);
        idleWatch(5, act);
        checkCount++;
        if (act !== 0) $display("[TB] FAIL stall_tail_activity got %0d want 0", act);
        else passCount++;
    endtask

    task automatic test_reset_mid_job();
        int act;
        runJob(8'd1, 8'h60, 8'h70, 0, 0, 100, 1, -1, 4);
        checkCount++;
        if (res_ready !== 1'b1) $display("[TB] FAIL abort_in_wait_res got res_ready %b want 1", res_ready);
        else passCount++;
        rst_n = 1'b0;
        res_valid = 1'b1;
        res_data = 128'h1234;
        @(negedge clk);
        checkCount++;
        if ({busy, done, error, mem_read_valid, mem_wreq, row_valid, res_ready} !== 7'b0 ||
            mem_addr !== 8'h00 || mem_din !== '0 || row_data !== '0)
            $display("[TB] FAIL abort_outputs got ctrl %b addr %h row %h want all zero",
                     {busy, done, error, mem_read_valid, mem_wreq, row_valid, res_ready}, mem_addr, row_data);
        else passCount++;
        rst_n = 1'b1;
        res_valid = 1'b0;
        idleWatch(6, act);
        checkCount++;
        if (act !== 0) $display("[TB] FAIL abort_no_access got %0d active cycles want 0", act);
        else passCount++;
    endtask

    initial begin
        passCount = 0; checkCount = 0;
        rst_n = 1'b0; start = 1'b0; row_count = '0; src_base = '0; dst_base = '0;
        sram_load_isfinsh = 1'b0; mem_read_finish = 1'b0; mem_dout = '0;
        row_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_zero_count();
        test_load_hold();
        test_timeout();
        test_back_to_back();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
